uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter on the processor data bus, alongside the data memory. It consumes the processor's store stream (write enable, address, write data) for its address window and buffers bytes in a small FIFO. It serialises them as 8N1 frames on a single output line. Reads return status and configuration combinationally, with the same timing as a data-memory read. The top level muxes this block's `rd` into the processor read data whenever `sel` is high.

---
 rtl/uart_tx_mmio.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: a store-fed byte FIFO drains into a
// start/data/stop serialiser whose bit time is a run-time programmable divisor.
module uart_tx_mmio #(
    parameter logic [31:0] BASE      = 32'h0000_0100,
    parameter int          DEPTH     = 8,
    parameter int          DIV_RESET = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        sel,
    output logic        tx
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        r_state, w_state_nxt;
    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wptr, r_rptr, w_wptr_inc, w_rptr_inc;
    logic [3:0]    r_count;
    logic          r_ovf;
    logic [15:0]   r_div;
    logic [15:0]   r_cnt, w_cnt_nxt;
    logic [2:0]    r_bit, w_bit_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic          r_tx, w_tx_nxt;
    logic          w_full, w_empty, w_busy, w_cnt_zero;
    logic          w_wr_txdata, w_wr_status, w_wr_div;
    logic          w_push, w_pop;
    logic [7:0]    w_head;

    assign sel         = (a[31:4] == BASE[31:4]);
    assign w_wr_txdata = we & sel & (a[3:2] == 2'd0);
    assign w_wr_status = we & sel & (a[3:2] == 2'd1);
    assign w_wr_div    = we & sel & (a[3:2] == 2'd2);

    assign w_full  = (r_count == 4'(DEPTH));
    assign w_empty = (r_count == 4'd0);
    assign w_busy  = (r_state != S_IDLE);
    assign w_push  = w_wr_txdata & ~w_full;
    assign w_head  = r_mem[r_rptr];
    assign tx      = r_tx;

    assign w_wptr_inc = (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
    assign w_rptr_inc = (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;

    always_comb begin
        rd = '0;
        if (sel) begin
            case (a[3:2])
                2'd1:    rd = {24'b0, r_count, r_ovf, w_empty, w_full, w_busy};
                2'd2:    rd = {16'b0, r_div};
                default: rd = '0;
            endcase
        end
    end

    // Storage only; contents are meaningless until the count says otherwise.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= wd[7:0];
        r_shift <= w_shift_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_div   <= 16'(DIV_RESET);
        end else begin
            if (w_push)
                r_wptr <= w_wptr_inc;
            if (w_pop)
                r_rptr <= w_rptr_inc;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
            if (w_wr_txdata & w_full)
                r_ovf <= 1'b1;
            else if (w_wr_status & wd[3])
                r_ovf <= 1'b0;
            if (w_wr_div)
                r_div <= (wd[15:0] == 16'd0) ? 16'd1 : wd[15:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    // tx is registered from the next-state view so the line changes on the
    // same edge that enters each bit; every reload samples the live divisor.
    assign w_cnt_zero = (r_cnt == 16'd0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head;
                    w_cnt_nxt   = r_div - 16'd1;
                    w_state_nxt = S_START;
                    w_tx_nxt    = 1'b0;
                end
            end
            S_START: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_DATA;
                    w_bit_nxt   = 3'd0;
                    w_cnt_nxt   = r_div - 16'd1;
                    w_tx_nxt    = r_shift[0];
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            S_DATA: begin
                if (w_cnt_zero) begin
                    w_cnt_nxt = r_div - 16'd1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_bit_nxt   = r_bit + 3'd1;
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_tx_nxt    = r_shift[1];
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            S_STOP: begin
                if (w_cnt_zero) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_head;
                        w_cnt_nxt   = r_div - 16'd1;
                        w_state_nxt = S_START;
                        w_tx_nxt    = 1'b0;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_tx_nxt    = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: directed scenarios plus random bus traffic, all
// checked cycle by cycle against a frame-level model of the transmitter.
module tb_uart_tx_mmio;

    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        sel;
    logic        tx;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_mmio #(.BASE(BASE), .DEPTH(DEPTH), .DIV_RESET(16)) dut (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .a     (a),
        .wd    (wd),
        .rd    (rd),
        .sel   (sel),
        .tx    (tx)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: a byte queue plus the frame in flight as ten line levels, the
    // index of the level being driven and the cycles it still has to run.
    logic [7:0]  m_q[$];
    bit          m_act;
    bit          m_bits[10];
    int          m_bidx;
    int          m_rem;
    logic [15:0] m_div;
    bit          m_ovf;

    function automatic void m_reset();
        m_q.delete();
        m_act  = 1'b0;
        m_bidx = 0;
        m_rem  = 0;
        m_div  = 16'd16;
        m_ovf  = 1'b0;
    endfunction

    function automatic void m_start();
        logic [7:0] b;
        b = m_q.pop_front();
        m_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) m_bits[i+1] = b[i];
        m_bits[9] = 1'b1;
        m_act  = 1'b1;
        m_bidx = 0;
        m_rem  = int'(m_div);
    endfunction

    function automatic void m_step(input bit w, input logic [31:0] ad, input logic [31:0] dat);
        bit was_full;
        bit was_nonempty;
        bit in_win;
        was_full     = (m_q.size() == DEPTH);
        was_nonempty = (m_q.size() != 0);
        in_win       = (ad[31:4] == BASE[31:4]);
        if (m_act) begin
            m_rem--;
            if (m_rem == 0) begin
                m_bidx++;
                if (m_bidx == 10) begin
                    m_act = 1'b0;
                    if (was_nonempty) m_start();
                end else begin
                    m_rem = int'(m_div);
                end
            end
        end else if (was_nonempty) begin
            m_start();
        end
        if (w && in_win) begin
            case (ad[3:2])
                2'd0: if (was_full) m_ovf = 1'b1; else m_q.push_back(dat[7:0]);
                2'd1: if (dat[3]) m_ovf = 1'b0;
                2'd2: m_div = (dat[15:0] == 16'd0) ? 16'd1 : dat[15:0];
                default: ;
            endcase
        end
    endfunction

    function automatic logic [31:0] exp_tx();
        return m_act ? 32'(m_bits[m_bidx]) : 32'd1;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] ad);
        if (ad[31:4] != BASE[31:4]) return 32'd0;
        case (ad[3:2])
            2'd1: return {24'b0, 4'(m_q.size()), m_ovf, (m_q.size() == 0),
                          (m_q.size() == DEPTH), m_act};
            2'd2: return {16'b0, m_div};
            default: return 32'd0;
        endcase
    endfunction

    // Entered 1 time unit after a rising edge; leaves at the same phase.
    // kind 1 also checks rd against kexp, kind 2 checks tx against kexp.
    task automatic cyc(input bit w, input logic [31:0] ad, input logic [31:0] dat,
                       input int kind = 0, input logic [31:0] kexp = 32'd0);
        we = w;
        a  = ad;
        wd = dat;
        #3;
        check("tx", 32'(tx), exp_tx());
        check("sel", 32'(sel), 32'(ad[31:4] == BASE[31:4]));
        check("rd", rd, exp_rd(ad));
        if (kind == 1) check("rd_const", rd, kexp);
        if (kind == 2) check("tx_const", 32'(tx), kexp);
        @(posedge clk);
        m_step(w, ad, dat);
        #1;
    endtask

    task automatic do_reset();
        we = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        m_reset();
        check("tx_async_rst", 32'(tx), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, BASE + 32'h4, 32'd0);
    endtask

    int seq[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    initial begin
        reset = 1'b1;
        we    = 1'b0;
        a     = 32'd0;
        wd    = 32'd0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset values
        cyc(1'b0, BASE + 32'h4, 32'd0, 1, 32'h4);
        cyc(1'b0, BASE + 32'h8, 32'd0, 1, 32'd16);
        do_reset();
        cyc(1'b0, BASE + 32'h4, 32'd0, 1, 32'h4);

        // Single byte 0xA5 at divisor 4
        cyc(1'b1, BASE + 32'h8, 32'd4);
        cyc(1'b1, BASE + 32'h0, 32'hFFFF_FFA5);
        cyc(1'b0, BASE + 32'h4, 32'd0, 2, 32'd1);
        for (int k = 0; k < 40; k++) cyc(1'b0, BASE + 32'h4, 32'd0, 2, 32'(seq[k/4]));
        cyc(1'b0, BASE + 32'h4, 32'd0, 1, 32'h4);

        // Back-to-back at divisor 2
        cyc(1'b1, BASE + 32'h8, 32'd2);
        cyc(1'b1, BASE + 32'h0, 32'h00);
        cyc(1'b1, BASE + 32'h0, 32'hFF);
        idle(45);

        // Overflow and ovf clear
        cyc(1'b1, BASE + 32'h8, 32'd100);
        for (int k = 0; k < 10; k++) cyc(1'b1, BASE + 32'h0, 32'(k + 8'h30));
        cyc(1'b0, BASE + 32'h4, 32'd0, 1, 32'h8B);
        cyc(1'b1, BASE + 32'h4, 32'h8);
        cyc(1'b0, BASE + 32'h4, 32'd0, 1, 32'h83);
        do_reset();
        cyc(1'b0, BASE + 32'h4, 32'd0, 1, 32'h4);

        // Divisor change during bit 2, then reset inside DATA
        cyc(1'b1, BASE + 32'h8, 32'd8);
        cyc(1'b1, BASE + 32'h0, 32'h55);
        idle(28);
        cyc(1'b1, BASE + 32'h8, 32'd2);
        idle(6);
        do_reset();
        cyc(1'b0, BASE + 32'h4, 32'd0, 1, 32'h4);
        cyc(1'b1, BASE + 32'h8, 32'd3);
        cyc(1'b1, BASE + 32'h0, 32'h3C);
        idle(35);

        // Decode: outside the window and the reserved offset
        cyc(1'b1, BASE + 32'h10, 32'h77);
        cyc(1'b0, BASE + 32'h10, 32'd0, 1, 32'd0);
        cyc(1'b1, BASE + 32'hC, 32'h77);
        cyc(1'b0, BASE + 32'hC, 32'd0, 1, 32'd0);
        cyc(1'b0, BASE + 32'h4, 32'd0, 1, 32'h4);
        cyc(1'b1, BASE + 32'h8, 32'd0);
        cyc(1'b0, BASE + 32'h8, 32'd0, 1, 32'd1);

        // Random bus traffic
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 10)
                cyc(1'b1, BASE, $urandom());
            else if (r < 14)
                cyc(1'b1, BASE + 32'h8, 32'($urandom_range(0, 4)) | ($urandom() & 32'hFFFF_0000));
            else if (r < 18)
                cyc(1'b1, BASE + 32'h4, $urandom());
            else if (r < 22)
                cyc(1'b1, BASE + 32'h10 * 32'($urandom_range(1, 200)) + 32'($urandom_range(0, 15)), $urandom());
            else if (r < 24)
                cyc(1'b1, BASE + 32'hC, $urandom());
            else if (r < 25)
                do_reset();
            else
                cyc(1'b0, BASE + 32'($urandom_range(0, 15)), $urandom());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
